// File: rtl/act_pkg.sv
// Shared types and defaults for the activation unit and its lanes.
package act_pkg;

    localparam int ACT_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLAMP  = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } act_state_e;

endpackage

// File: rtl/act_lane.sv
// Single-element activation function; purely combinational.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W_DEF
) (
    input  logic [DATA_W-1:0] x_i,
    input  act_mode_e         mode_i,
    input  logic [4:0]        leak_shift_i,
    input  logic [DATA_W-1:0] clamp_max_i,
    output logic [DATA_W-1:0] y_o,
    output logic              is_neg_o
);

    logic signed [DATA_W-1:0] leak_val;
    logic                     x_neg;

    assign x_neg    = x_i[DATA_W-1];
    assign is_neg_o = x_neg;

    // Kept in its own signed variable so the shift stays arithmetic.
    always_comb begin
        leak_val = $signed(x_i) >>> leak_shift_i;
    end

    always_comb begin
        y_o = x_i;
        case (mode_i)
            ACT_BYPASS: y_o = x_i;
            ACT_RELU: begin
                if (x_neg) y_o = '0;
            end
            ACT_LEAKY: begin
                if (x_neg) y_o = leak_val;
            end
            ACT_CLAMP: begin
                // A negative ceiling forces everything to zero.
                if (x_neg || clamp_max_i[DATA_W-1]) begin
                    y_o = '0;
                end else if ($signed(x_i) > $signed(clamp_max_i)) begin
                    y_o = clamp_max_i;
                end
            end
            default: y_o = x_i;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// Pipelined activation stage: latches a vector, processes LANES elements per
// beat, then holds the result and negative-input count until consumed.
//
//   state | meaning
//   IDLE  | ready for a new vector; last result still visible on out_vec
//   RUN   | one slice of LANES elements processed per cycle
//   HOLD  | result valid, waiting for out_ready
module activation_unit
    import act_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W_DEF,
    parameter int VECTOR_LEN = 3,
    parameter int LANES      = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode,
    input  logic [4:0]                       leak_shift,
    input  logic [DATA_W-1:0]                clamp_max,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VECTOR_LEN*DATA_W-1:0]     in_vec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VECTOR_LEN*DATA_W-1:0]     out_vec,
    output logic [$clog2(VECTOR_LEN+1)-1:0]  neg_count,
    output logic                             busy
);

    localparam int BEATS  = VECTOR_LEN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NC_W   = $clog2(VECTOR_LEN + 1);
    localparam int SLC_W  = LANES * DATA_W;
    localparam int VEC_W  = VECTOR_LEN * DATA_W;

    act_state_e         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    act_mode_e          mode_q, mode_d;
    logic [4:0]         shift_q, shift_d;
    logic [DATA_W-1:0]  clamp_q, clamp_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   out_q, out_d;
    logic [NC_W-1:0]    neg_q, neg_d;

    logic [SLC_W-1:0]   slice_x;
    logic [SLC_W-1:0]   slice_y;
    logic [LANES-1:0]   slice_neg;
    logic [NC_W-1:0]    slice_cnt;
    logic               last_beat;

    always_comb begin
        slice_x = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) slice_x = vec_q[b*SLC_W +: SLC_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        act_lane #(.DATA_W(DATA_W)) u_lane (
            .x_i          (slice_x[l*DATA_W +: DATA_W]),
            .mode_i       (mode_q),
            .leak_shift_i (shift_q),
            .clamp_max_i  (clamp_q),
            .y_o          (slice_y[l*DATA_W +: DATA_W]),
            .is_neg_o     (slice_neg[l])
        );
    end

    always_comb begin
        slice_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            slice_cnt = slice_cnt + NC_W'(slice_neg[l]);
        end
    end

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        clamp_d = clamp_q;
        vec_d   = vec_q;
        out_d   = out_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_vec;
                    mode_d  = act_mode_e'(mode);
                    shift_d = leak_shift;
                    clamp_d = clamp_max;
                    beat_d  = '0;
                    neg_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_q == BEAT_W'(b)) out_d[b*SLC_W +: SLC_W] = slice_y;
                end
                neg_d = neg_q + slice_cnt;
                if (last_beat) begin
                    state_d = HOLD;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mode_q  <= ACT_BYPASS;
            shift_q <= '0;
            clamp_q <= '0;
            vec_q   <= '0;
            out_q   <= '0;
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            clamp_q <= clamp_d;
            vec_q   <= vec_d;
            out_q   <= out_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_vec   = out_q;
    assign neg_count = neg_q;

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: one-lane and three-lane instances.
module tb_activation_unit;
    import act_pkg::*;

    localparam int DW = 32;
    localparam int VL = 3;

    typedef struct packed {
        logic [VL*DW-1:0] v;
        logic [1:0]       n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       mode1, mode3;
    logic [4:0]       shift1, shift3;
    logic [DW-1:0]    cmax1, cmax3;
    logic             in_valid1, in_valid3, in_ready1, in_ready3;
    logic             out_valid1, out_valid3, out_ready1, out_ready3;
    logic             busy1, busy3;
    logic [VL*DW-1:0] in_vec1, in_vec3, out_vec1, out_vec3;
    logic [1:0]       neg1, neg3;

    activation_unit #(.DATA_W(DW), .VECTOR_LEN(VL), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .leak_shift(shift1), .clamp_max(cmax1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_vec(out_vec1),
        .neg_count(neg1), .busy(busy1)
    );

    activation_unit #(.DATA_W(DW), .VECTOR_LEN(VL), .LANES(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .leak_shift(shift3), .clamp_max(cmax3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_vec(in_vec3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_vec(out_vec3),
        .neg_count(neg3), .busy(busy3)
    );

    exp_t sb1[$];
    exp_t sb3[$];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VL*DW-1:0] p3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [1:0] m,
                                           input logic [4:0] s, input logic [DW-1:0] c);
        logic signed [DW-1:0] xs, cs, sh;
        xs = x;
        cs = c;
        sh = xs >>> s;
        case (m)
            2'd1: if (xs < 0) return '0;
            2'd2: if (xs < 0) return sh;
            2'd3: begin
                if (xs < 0 || cs < 0) return '0;
                if (xs > cs) return c;
            end
            default: ;
        endcase
        return x;
    endfunction

    task automatic push_exp(input int sel, input logic [VL*DW-1:0] v, input logic [1:0] n);
        exp_t e;
        e.v = v;
        e.n = n;
        if (sel == 1) sb1.push_back(e);
        else sb3.push_back(e);
    endtask

    task automatic send(input int sel, input logic [VL*DW-1:0] v, input logic [1:0] m,
                        input logic [4:0] s, input logic [DW-1:0] c);
        int n = 0;
        while (((sel == 1) ? in_ready1 : in_ready3) !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq("in_ready_wait", 128'(((sel == 1) ? in_ready1 : in_ready3)), 128'(1));
        if (sel == 1) begin
            in_vec1 = v; mode1 = m; shift1 = s; cmax1 = c; in_valid1 = 1'b1;
        end else begin
            in_vec3 = v; mode3 = m; shift3 = s; cmax3 = c; in_valid3 = 1'b1;
        end
        @(posedge clk); #1;
        if (sel == 1) in_valid1 = 1'b0;
        else in_valid3 = 1'b0;
    endtask

    // Waits for out_valid, compares against the scoreboard head, optionally consumes.
    task automatic recv(input int sel, input int exp_lat, input string tag, input bit consume);
        int   lat = 0;
        exp_t e;
        while (((sel == 1) ? out_valid1 : out_valid3) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        if (sel == 1) begin
            check_eq({tag, "_sb"}, 128'(sb1.size() > 0), 128'(1));
            if (sb1.size() > 0) e = sb1.pop_front();
            check_eq({tag, "_vec"}, 128'(out_vec1), 128'(e.v));
            check_eq({tag, "_neg"}, 128'(neg1), 128'(e.n));
        end else begin
            check_eq({tag, "_sb"}, 128'(sb3.size() > 0), 128'(1));
            if (sb3.size() > 0) e = sb3.pop_front();
            check_eq({tag, "_vec"}, 128'(out_vec3), 128'(e.v));
            check_eq({tag, "_neg"}, 128'(neg3), 128'(e.n));
        end
        if (consume) begin
            if (sel == 1) out_ready1 = 1'b1;
            else out_ready3 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            out_ready3 = 1'b0;
            check_eq({tag, "_drop"}, 128'(((sel == 1) ? out_valid1 : out_valid3)), 128'(0));
        end
    endtask

    initial begin
        logic [VL*DW-1:0] held;
        logic [VL*DW-1:0] rv, ev;
        logic [1:0]       rm, en;
        logic [4:0]       rs;
        logic [DW-1:0]    rc;

        mode1 = '0; shift1 = '0; cmax1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_vec1 = '0;
        mode3 = '0; shift3 = '0; cmax3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_vec3 = '0;
        #1 rst = 1'b1;
        #1;
        check_eq("rst_in_ready", 128'(in_ready1), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid1), 128'(0));
        check_eq("rst_busy", 128'(busy1), 128'(0));
        check_eq("rst_out_vec", 128'(out_vec1), 128'(0));
        check_eq("rst_neg", 128'(neg1), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        push_exp(1, p3(0, 0, 7), 2'd1);
        send(1, p3(-5, 0, 7), 2'd1, 5'd0, 32'd0);
        check_eq("relu_busy", 128'(busy1), 128'(1));
        recv(1, 3, "relu", 1'b1);

        push_exp(1, p3(-2, -1, 12), 2'd2);
        send(1, p3(-8, -1, 12), 2'd2, 5'd2, 32'd0);
        recv(1, 3, "leaky2", 1'b1);

        push_exp(1, p3(-1, 5, -1), 2'd2);
        send(1, p3(32'h8000_0000, 5, -32), 2'd2, 5'd31, 32'd0);
        recv(1, 3, "leaky31", 1'b1);

        push_exp(1, p3(0, 4, 6), 2'd1);
        send(1, p3(-3, 4, 100), 2'd3, 5'd0, 32'd6);
        recv(1, 3, "clamp6", 1'b1);

        push_exp(1, p3(0, 0, 0), 2'd1);
        send(1, p3(5, -5, 0), 2'd3, 5'd0, -32'sd1);
        recv(1, 3, "clampneg", 1'b1);

        push_exp(3, p3(-1, 2, -3), 2'd2);
        send(3, p3(-1, 2, -3), 2'd0, 5'd0, 32'd0);
        recv(3, 1, "l3_bypass", 1'b1);

        push_exp(3, p3(0, 0, 7), 2'd1);
        send(3, p3(-5, 0, 7), 2'd1, 5'd0, 32'd0);
        recv(3, 1, "l3_relu", 1'b1);

        // Backpressure: result must stay put while inputs churn.
        held = p3(1, -2, 3);
        push_exp(1, held, 2'd1);
        send(1, p3(1, -2, 3), 2'd0, 5'd0, 32'd0);
        recv(1, 3, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_vec1 = {$urandom, $urandom, $urandom};
            mode1 = 2'(i);
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            check_eq("bp_vec", 128'(out_vec1), 128'(held));
            check_eq("bp_in_ready", 128'(in_ready1), 128'(0));
            check_eq("bp_valid", 128'(out_valid1), 128'(1));
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check_eq("bp_release", 128'(out_valid1), 128'(0));
        check_eq("bp_holdvec", 128'(out_vec1), 128'(held));
        push_exp(1, p3(-2, 6, -4), 2'd2);
        send(1, p3(-4, 6, -7), 2'd2, 5'd1, 32'd0);
        recv(1, 3, "bp_next", 1'b1);

        // Reset in flight discards the vector.
        send(1, p3(-9, 9, -9), 2'd0, 5'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 128'(out_valid1), 128'(0));
        check_eq("mid_rst_vec", 128'(out_vec1), 128'(0));
        check_eq("mid_rst_neg", 128'(neg1), 128'(0));
        check_eq("mid_rst_busy", 128'(busy1), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        check_eq("post_rst_ready", 128'(in_ready1), 128'(1));
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("post_rst_nohs", 128'(out_valid1), 128'(0));
        end
        push_exp(1, p3(0, 9, 0), 2'd2);
        send(1, p3(-9, 9, -9), 2'd1, 5'd0, 32'd0);
        recv(1, 3, "post_rst", 1'b1);

        for (int k = 0; k < 8; k++) begin
            rv = {$urandom, $urandom, $urandom};
            rm = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            rc = (k % 3 == 2) ? -32'sd7 : 32'($urandom_range(0, 100000));
            en = '0;
            for (int j = 0; j < VL; j++) begin
                ev[j*DW +: DW] = model(rv[j*DW +: DW], rm, rs, rc);
                en = en + 2'(rv[j*DW + DW - 1]);
            end
            push_exp(1, ev, en);
            send(1, rv, rm, rs, rc);
            recv(1, 3, "rand1", 1'b1);
            push_exp(3, ev, en);
            send(3, rv, rm, rs, rc);
            recv(3, 1, "rand3", 1'b1);
        end

        check_eq("sb1_empty", 128'(sb1.size()), 128'(0));
        check_eq("sb3_empty", 128'(sb3.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activation_unit.md
# activation_unit

Parametrised, pipelined successor to the combinational ReLU stage. It accepts one activation vector per handshake and processes it `LANES` elements per cycle in one of four runtime-selectable modes: bypass, ReLU, leaky ReLU, clamped ReLU. It returns the result vector with a count of negative inputs. It sits between a layer's accumulator output and the next layer's input buffer, with valid/ready handshakes on both sides.

## Interface
- `DATA_W`, 32: element width, signed two's complement.
- `VECTOR_LEN`, 3: elements per vector. Must be a multiple of `LANES`.
- `LANES`, 1: elements processed per cycle. `BEATS = VECTOR_LEN/LANES`.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `mode` input, 2: 0 bypass, 1 relu, 2 leaky, 3 clamp. Sampled at the input handshake.
- `leak_shift` input, 5: arithmetic right-shift amount for leaky mode. Sampled at the input handshake.
- `clamp_max` input, `DATA_W`: signed upper bound for clamp mode. Sampled at the input handshake.
- `in_valid` input, 1: `in_vec` holds a valid vector.
- `in_ready` output, 1: the block can accept a vector.
- `in_vec` input, `VECTOR_LEN`×`DATA_W`: input vector.
- `out_valid` output, 1: `out_vec` and `neg_count` are valid.
- `out_ready` input, 1: the consumer accepts the result.
- `out_vec` output, `VECTOR_LEN`×`DATA_W`: result vector.
- `neg_count` output, `$clog2(VECTOR_LEN+1)`: number of input elements with the sign bit set.
- `busy` output, 1: high in `RUN` and `HOLD`.

## Operation
- FSM `IDLE` → `RUN` → `HOLD` → `IDLE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_vec`, `mode`, `leak_shift` and `clamp_max`; clear the beat counter and `neg_count`; go to `RUN`.
- `RUN`:
  - Each cycle, process elements `[beat*LANES +: LANES]` of the latched vector into the output buffer.
  - Add the number of sign-set elements in that slice to `neg_count`.
  - When `beat==BEATS-1`, go to `HOLD`; otherwise increment `beat`.
- `HOLD`:
  - `out_valid`=1; `out_vec` and `neg_count` are stable.
  - On `out_ready`, go to `IDLE`.
- `in_ready`=1 only in `IDLE`. Input changes outside `IDLE` are ignored.
- Per-element function, with x signed `DATA_W`:
  - bypass: x.
  - relu: x<0 ? 0 : x.
  - leaky: x<0 ? (x >>> leak_shift) : x. Arithmetic shift, rounds toward −inf; a negative result never exceeds −1 unless it is 0 at shift 0 (n/a).
  - clamp: x<0 ? 0 : (x>clamp_max ? clamp_max : x). If `clamp_max`<0, every output is 0.
- The sign test is bit `DATA_W-1` only. No overflow is possible in any mode.
- `neg_count` counts sign-set inputs in every mode, including bypass.

## Timing
- Reset (async assert, state cleared immediately):
  - State `IDLE`.
  - `in_ready`=1 after reset.
  - `out_valid`=0, `busy`=0, `out_vec`=all 0, `neg_count`=0.
  - Beat counter 0.
- Reset asserted in `RUN` or `HOLD` discards the vector in flight. No output handshake occurs for it.
- Latency: input handshake at edge T gives `out_valid`=1 after edge T+`BEATS`.
- Throughput: at most one vector per `BEATS`+2 cycles with `out_ready` held high.
- `out_valid` and `out_vec` never change while `out_valid`=1 and `out_ready`=0.
- `out_vec` holds its last result after the output handshake until the next vector overwrites it, beat by beat.
- Degenerate case `BEATS`=1: `RUN` lasts exactly one cycle.

## Structure
- Package `act_pkg`:
  - `act_mode_e` enum: `ACT_BYPASS`, `ACT_RELU`, `ACT_LEAKY`, `ACT_CLAMP`.
  - `act_state_e` enum: `IDLE`, `RUN`, `HOLD`.
  - Default `DATA_W` constant.
- Sub-module `act_lane`: purely combinational single-element function, inputs x, mode, `leak_shift`, `clamp_max`; outputs y and `is_neg`. Instantiated `LANES` times.
- Top level holds the FSM, beat counter, config registers, input and output vector registers, and the `neg_count` accumulator.

## Test plan
- relu, `VECTOR_LEN`=3, `LANES`=1, in [-5,0,7] → out [0,0,7], `neg_count`=1, `out_valid` 3 cycles after the input handshake.
- leaky, `leak_shift`=2, in [-8,-1,12] → [-2,-1,12], `neg_count`=2. Also in [-2^31] with shift 31 → [-1].
- clamp, `clamp_max`=6, in [-3,4,100] → [0,4,6]. With `clamp_max`=-1, in [5,-5,0] → [0,0,0].
- `LANES`=3, bypass, in [-1,2,-3] → identical output, `neg_count`=2, `out_valid` 1 cycle after the handshake.
- Backpressure: hold `out_ready`=0 for 5 cycles while toggling `in_vec` and `mode` → `out_vec` stable, `in_ready`=0, no second vector accepted. After `out_ready` goes high, the next vector uses the newly sampled config.
- Assert `rst` mid-`RUN` → `out_valid`=0, `out_vec`=0, `neg_count`=0 immediately. After release, `in_ready`=1 and a fresh vector completes correctly.
